// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: datapath width, RV32I opcodes
// used by the stage, load/store size codes, FSM state encoding and a helper
// that maps an access size code to the index of its last byte.
package mem_stage_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_ALOPI = 7'b0010011;

   localparam logic [XLEN_DEF-1:0] ZERO_WORD = '0;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mem_state_e;

   // Byte counter value of the final byte: 1, 2 or 4 bytes from funct3[1:0];
   // the two upper size codes both mean a full word.
   function automatic logic [1:0] last_byte_idx(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 2'd0;
         2'b01:   return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Byte-wide memory controller port of the MEM stage.
//   mem_req   stage -> ctrl  byte access request
//   mem_wr    stage -> ctrl  1 = write, 0 = read
//   mem_addr  stage -> ctrl  byte address
//   mem_dout  stage -> ctrl  write byte
//   mem_din   ctrl -> stage  read byte, valid while mem_done=1
//   mem_done  ctrl -> stage  one-cycle completion pulse for the current byte
interface mem_stage_if
   import mem_stage_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) ();

   logic            mem_req;
   logic            mem_wr;
   logic [XLEN-1:0] mem_addr;
   logic [7:0]      mem_dout;
   logic [7:0]      mem_din;
   logic            mem_done;

   modport master (
      output mem_req, mem_wr, mem_addr, mem_dout,
      input  mem_din, mem_done
   );

   modport slave (
      input  mem_req, mem_wr, mem_addr, mem_dout,
      output mem_din, mem_done
   );

endinterface

// File: rtl/mem_load_ext.sv
// Load data extension: turns the assembled little-endian byte buffer into the
// register value according to the load size/sign code.
//   byte_buf  in   32    assembled load bytes, byte 0 in [7:0]
//   funct3    in   3     load size/sign code
//   ext_val   out  XLEN  sign- or zero-extended result
module mem_load_ext
   import mem_stage_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [31:0]     byte_buf,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] ext_val
);

   always_comb begin
      ext_val = '0;
      case (funct3)
         F3_LB:   ext_val = {{(XLEN-8){byte_buf[7]}}, byte_buf[7:0]};
         F3_LH:   ext_val = {{(XLEN-16){byte_buf[15]}}, byte_buf[15:0]};
         F3_LBU:  ext_val = {{(XLEN-8){1'b0}}, byte_buf[7:0]};
         F3_LHU:  ext_val = {{(XLEN-16){1'b0}}, byte_buf[15:0]};
         // LW and the unused codes: the buffer holds the full word.
         default: ext_val = XLEN'(byte_buf);
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage of the RV32I core (between EX/MEM and MEM_WB).
// Non-memory ops pass straight through. Loads and stores run byte-serially on
// the 8-bit memory controller port while the pipeline is stalled; load bytes
// are assembled and extended before going to MEM_WB.
//   clk_in        in   clock, all state on posedge
//   rst_in        in   synchronous reset, active-low
//   rdy_in        in   global ready, 0 freezes all state
//   ins_type      in   opcode from EX/MEM
//   funct3        in   access size/sign
//   rd_addr       in   destination register
//   alu_val       in   ALU result / effective address
//   store_val     in   store data (rs2)
//   mem           --   byte memory port (master side)
//   stall_req     out  holds EX/MEM and upstream stages
//   out_rd_addr   out  to MEM_WB
//   out_rd_val    out  to MEM_WB
//   out_ins_type  out  to MEM_WB
//
// state | meaning
// IDLE  | pass-through; a load/store here stalls and latches the request
// BUSY  | one byte access per mem_done, counter selects the byte
// DONE  | one cycle presenting the completed access to MEM_WB
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int         XLEN     = XLEN_DEF,
   parameter logic [6:0] NOP_TYPE = OPC_ALOPI
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            rdy_in,
   input  logic [6:0]      ins_type,
   input  logic [2:0]      funct3,
   input  logic [4:0]      rd_addr,
   input  logic [XLEN-1:0] alu_val,
   input  logic [XLEN-1:0] store_val,
   mem_stage_if.master     mem,
   output logic            stall_req,
   output logic [4:0]      out_rd_addr,
   output logic [XLEN-1:0] out_rd_val,
   output logic [6:0]      out_ins_type
);

   mem_state_e      state, state_nxt;
   logic [1:0]      cnt;
   logic [XLEN-1:0] addr_lat;
   logic [31:0]     store_lat;
   logic [2:0]      f3_lat;
   logic [4:0]      rd_lat;
   logic [6:0]      ins_lat;
   logic [31:0]     byte_buf;

   logic            lat_en;
   logic            cnt_inc;
   logic            buf_wr;
   logic            is_mem_in;
   logic            is_load_lat;
   logic            is_store_lat;
   logic [4:0]      byte_sel;
   logic [XLEN-1:0] ext_val;

   assign is_mem_in    = (ins_type == OPC_LOAD) || (ins_type == OPC_STORE);
   assign is_load_lat  = (ins_lat == OPC_LOAD);
   assign is_store_lat = (ins_lat == OPC_STORE);
   assign byte_sel     = {cnt, 3'b000};

   mem_load_ext #(.XLEN(XLEN)) u_load_ext (
      .byte_buf (byte_buf),
      .funct3   (f3_lat),
      .ext_val  (ext_val)
   );

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         addr_lat  <= '0;
         store_lat <= '0;
         f3_lat    <= '0;
         rd_lat    <= '0;
         ins_lat   <= '0;
         byte_buf  <= '0;
      end else if (rdy_in) begin
         state <= state_nxt;
         if (lat_en) begin
            addr_lat  <= alu_val;
            store_lat <= store_val[31:0];
            f3_lat    <= funct3;
            rd_lat    <= rd_addr;
            ins_lat   <= ins_type;
            cnt       <= '0;
            byte_buf  <= '0;
         end else begin
            if (cnt_inc) cnt <= cnt + 2'd1;
            if (buf_wr)  byte_buf[byte_sel +: 8] <= mem.mem_din;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      lat_en       = 1'b0;
      cnt_inc      = 1'b0;
      buf_wr       = 1'b0;
      mem.mem_req  = 1'b0;
      mem.mem_wr   = 1'b0;
      mem.mem_addr = '0;
      mem.mem_dout = '0;
      stall_req    = 1'b0;
      out_ins_type = ins_type;
      out_rd_addr  = rd_addr;
      out_rd_val   = alu_val;

      case (state)
         ST_IDLE: begin
            if (is_mem_in) begin
               stall_req    = 1'b1;
               out_ins_type = NOP_TYPE;
               out_rd_addr  = '0;
               out_rd_val   = '0;
               lat_en       = 1'b1;
               state_nxt    = ST_BUSY;
            end
         end

         ST_BUSY: begin
            // mem_done only counts while rdy_in=1; the register gating makes
            // buf_wr/cnt_inc/state_nxt inert otherwise.
            mem.mem_req  = rdy_in;
            mem.mem_wr   = is_store_lat;
            mem.mem_addr = addr_lat + XLEN'(cnt);
            mem.mem_dout = store_lat[byte_sel +: 8];
            stall_req    = 1'b1;
            out_ins_type = NOP_TYPE;
            out_rd_addr  = '0;
            out_rd_val   = '0;
            if (mem.mem_done) begin
               buf_wr = is_load_lat;
               if (cnt == last_byte_idx(f3_lat)) state_nxt = ST_DONE;
               else                              cnt_inc   = 1'b1;
            end
         end

         ST_DONE: begin
            out_ins_type = ins_lat;
            out_rd_addr  = rd_lat;
            out_rd_val   = is_load_lat ? ext_val : '0;
            state_nxt    = ST_IDLE;
         end

         default: state_nxt = ST_IDLE;
      endcase

      // Reset overrides everything combinationally so a request in flight
      // drops in the same cycle.
      if (!rst_in) begin
         mem.mem_req  = 1'b0;
         mem.mem_wr   = 1'b0;
         stall_req    = 1'b0;
         out_ins_type = NOP_TYPE;
         out_rd_addr  = '0;
         out_rd_val   = '0;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk_in, rst_in, rdy_in;
   logic [6:0]  ins_type;
   logic [2:0]  funct3;
   logic [4:0]  rd_addr;
   logic [31:0] alu_val, store_val;
   logic        stall_req;
   logic [4:0]  out_rd_addr;
   logic [31:0] out_rd_val;
   logic [6:0]  out_ins_type;

   mem_stage_if #(.XLEN(32)) mbus ();

   mem_stage dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .rdy_in       (rdy_in),
      .ins_type     (ins_type),
      .funct3       (funct3),
      .rd_addr      (rd_addr),
      .alu_val      (alu_val),
      .store_val    (store_val),
      .mem          (mbus),
      .stall_req    (stall_req),
      .out_rd_addr  (out_rd_addr),
      .out_rd_val   (out_rd_val),
      .out_ins_type (out_ins_type)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // ---------------- memory model / responder ----------------
   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [7:0]  data;
   } acc_t;

   logic [7:0] mem [logic [31:0]];
   acc_t       log_q[$];
   int         gap_mode   = 0;   // 0 every cycle, 1 alternate, 2 random
   bit         gap_toggle = 0;
   bit         fire;

   function automatic logic [7:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a[7:0] ^ 8'hA5;
   endfunction

   function automatic int nbytes_of(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
      longint v;
      int     nb;
      v  = 0;
      nb = nbytes_of(f3);
      for (int i = 0; i < nb; i++)
         v += longint'(mem_rd(addr + 32'(i))) * (longint'(1) << (8 * i));
      if (f3 == 3'd0 && v >= 128)   v -= 256;
      if (f3 == 3'd1 && v >= 32768) v -= 65536;
      return v[31:0];
   endfunction

   initial begin
      mbus.mem_done = 1'b0;
      mbus.mem_din  = 8'h00;
   end

   always begin
      @(negedge clk_in);
      if (mbus.mem_req) begin
         fire = 1'b1;
         if (gap_mode == 1) begin
            fire       = gap_toggle;
            gap_toggle = !gap_toggle;
         end else if (gap_mode == 2) begin
            fire = ($urandom_range(0, 1) == 1);
         end
         if (fire) begin
            mbus.mem_done = 1'b1;
            if (mbus.mem_wr) begin
               mem[mbus.mem_addr] = mbus.mem_dout;
               log_q.push_back('{mbus.mem_addr, 1'b1, mbus.mem_dout});
            end else begin
               mbus.mem_din = mem_rd(mbus.mem_addr);
               log_q.push_back('{mbus.mem_addr, 1'b0, mbus.mem_din});
            end
         end
      end
      @(posedge clk_in);
      #1;
      mbus.mem_done = 1'b0;
   end

   // ---------------- transaction helpers ----------------
   task automatic bubble();
      ins_type  = OPC_ALOPI;
      funct3    = 3'd0;
      rd_addr   = 5'd0;
      alu_val   = 32'd0;
      store_val = 32'd0;
   endtask

   task automatic do_pass(input logic [6:0] ins, input logic [4:0] rd, input logic [31:0] val);
      tick();
      ins_type = ins; rd_addr = rd; alu_val = val; funct3 = 3'd0;
      @(negedge clk_in);
      chk("pass_val",   out_rd_val,   val);
      chk("pass_rd",    out_rd_addr,  {27'd0, rd});
      chk("pass_ins",   out_ins_type, {25'd0, ins});
      chk("pass_stall", stall_req,    32'd0);
      chk("pass_req",   mbus.mem_req, 32'd0);
   endtask

   task automatic do_txn(input logic [6:0] ins, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] sval, input int mode,
                         input logic [31:0] exp_val, input int exp_stall);
      int          nb, stalls;
      bit          done;
      bit          is_st;
      logic [31:0] sh;
      nb    = nbytes_of(f3);
      is_st = (ins == OPC_STORE);
      tick();
      gap_mode = mode; gap_toggle = 1'b0; log_q.delete();
      ins_type = ins; funct3 = f3; rd_addr = rd; alu_val = addr; store_val = sval;
      stalls = 0; done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk_in);
         if (stall_req) begin
            stalls++;
            chk("busy_ins_nop", out_ins_type, {25'd0, OPC_ALOPI});
         end else begin
            done = 1'b1;
         end
      end
      if (!done) chk("timeout_stall", stall_req, 32'd0);
      chk("done_ins",  out_ins_type, {25'd0, ins});
      chk("done_rd",   out_rd_addr,  {27'd0, rd});
      chk("done_val",  out_rd_val,   exp_val);
      chk("done_req",  mbus.mem_req, 32'd0);
      if (exp_stall > 0) chk("stall_cycles", stalls, exp_stall);
      chk("n_access", log_q.size(), nb);
      for (int i = 0; i < nb && i < log_q.size(); i++) begin
         chk("acc_addr", log_q[i].addr, addr + 32'(i));
         chk("acc_wr",   log_q[i].wr,   {31'd0, is_st});
         if (is_st) begin
            sh = sval >> (8 * i);
            chk("acc_wdata", log_q[i].data, {24'd0, sh[7:0]});
         end
      end
      tick();
      bubble();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [6:0]  ins;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] addr;
      logic [31:0] sval;
      logic [31:0] word;
      int          mode;
      logic [31:0] exp_val;
      int          exp_stall;
   } vec_t;

   vec_t vt [13];

   initial begin
      logic [6:0]  r_ins;
      logic [2:0]  r_f3;
      logic [31:0] r_addr, r_sval, r_exp, w;
      int          r_mode, sel;

      vt[0]  = '{OPC_ALOPI,  3'd0, 5'd5,  32'h0000_1234, 32'h0, 32'h0,         0, 32'h0000_1234, 0};
      vt[1]  = '{OPC_LOAD,   3'd0, 5'd1,  32'h0000_0100, 32'h0, 32'h0000_0080, 0, 32'hFFFF_FF80, 2};
      vt[2]  = '{OPC_LOAD,   3'd2, 5'd2,  32'h0000_0FFF, 32'h0, 32'h4433_2211, 1, 32'h4433_2211, 0};
      vt[3]  = '{OPC_STORE,  3'd1, 5'd11, 32'h0000_0020, 32'hABCD_1234, 32'h0, 0, 32'h0, 3};
      vt[4]  = '{OPC_LOAD,   3'd1, 5'd3,  32'h0000_0041, 32'h0, 32'h0000_8001, 0, 32'hFFFF_8001, 3};
      vt[5]  = '{OPC_LOAD,   3'd5, 5'd4,  32'h0000_0041, 32'h0, 32'h0000_8001, 0, 32'h0000_8001, 3};
      vt[6]  = '{OPC_LOAD,   3'd4, 5'd6,  32'h0000_0007, 32'h0, 32'h0000_00F0, 0, 32'h0000_00F0, 2};
      vt[7]  = '{OPC_LOAD,   3'd3, 5'd8,  32'h0000_0200, 32'h0, 32'h7856_3412, 0, 32'h7856_3412, 5};
      vt[8]  = '{OPC_LOAD,   3'd2, 5'd9,  32'hFFFF_FFFE, 32'h0, 32'hDDCC_BBAA, 2, 32'hDDCC_BBAA, 0};
      vt[9]  = '{OPC_STORE,  3'd0, 5'd12, 32'h0000_0030, 32'h1234_56EF, 32'h0, 0, 32'h0, 2};
      vt[10] = '{OPC_STORE,  3'd2, 5'd13, 32'h0000_0033, 32'hDEAD_BEEF, 32'h0, 1, 32'h0, 0};
      vt[11] = '{7'b0110011, 3'd0, 5'd31, 32'hCAFE_BABE, 32'h0, 32'h0,         0, 32'hCAFE_BABE, 0};
      vt[12] = '{OPC_LOAD,   3'd1, 5'd10, 32'h0000_0080, 32'h0, 32'h0000_7FFF, 0, 32'h0000_7FFF, 3};

      // reset: outputs forced even with a load presented
      rst_in = 1'b0; rdy_in = 1'b1;
      ins_type = OPC_LOAD; funct3 = 3'd2; rd_addr = 5'd5; alu_val = 32'h55; store_val = 32'h0;
      tick(); tick();
      @(negedge clk_in);
      chk("rst_req",   mbus.mem_req, 32'd0);
      chk("rst_stall", stall_req,    32'd0);
      chk("rst_ins",   out_ins_type, {25'd0, OPC_ALOPI});
      chk("rst_rd",    out_rd_addr,  32'd0);
      chk("rst_val",   out_rd_val,   32'd0);
      tick();
      rst_in = 1'b1;
      bubble();

      for (int i = 0; i < 13; i++) begin
         if (vt[i].ins == OPC_LOAD || vt[i].ins == OPC_STORE) begin
            if (vt[i].ins == OPC_LOAD)
               for (int b = 0; b < 4; b++) begin
                  w = vt[i].word >> (8 * b);
                  mem[vt[i].addr + 32'(b)] = w[7:0];
               end
            do_txn(vt[i].ins, vt[i].f3, vt[i].rd, vt[i].addr, vt[i].sval,
                   vt[i].mode, vt[i].exp_val, vt[i].exp_stall);
         end else begin
            do_pass(vt[i].ins, vt[i].rd, vt[i].addr);
         end
      end

      // rdy_in freeze in the middle of a word load
      mem[32'h500] = 8'h01; mem[32'h501] = 8'h02; mem[32'h502] = 8'h03; mem[32'h503] = 8'h84;
      tick();
      gap_mode = 0; log_q.delete();
      ins_type = OPC_LOAD; funct3 = 3'd2; rd_addr = 5'd7; alu_val = 32'h500;
      @(negedge clk_in);
      chk("frz_stall0", stall_req, 32'd1);
      tick();
      @(negedge clk_in);
      chk("frz_addr0", mbus.mem_addr, 32'h500);
      tick();
      rdy_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_in);
         chk("frz_req", mbus.mem_req, 32'd0);
         tick();
      end
      rdy_in = 1'b1;
      @(negedge clk_in);
      chk("frz_resume_req",  mbus.mem_req,  32'd1);
      chk("frz_resume_addr", mbus.mem_addr, 32'h501);
      begin
         bit fd;
         fd = 1'b0;
         for (int c = 0; c < 20 && !fd; c++) begin
            tick();
            @(negedge clk_in);
            if (!stall_req) fd = 1'b1;
         end
         if (!fd) chk("frz_timeout", stall_req, 32'd0);
      end
      chk("frz_val", out_rd_val, 32'h8403_0201);
      chk("frz_n",   log_q.size(), 32'd4);
      for (int i = 0; i < 4 && i < log_q.size(); i++)
         chk("frz_acc_addr", log_q[i].addr, 32'h500 + 32'(i));
      tick();
      bubble();

      // reset while BUSY
      tick();
      gap_mode = 0; log_q.delete();
      ins_type = OPC_LOAD; funct3 = 3'd2; rd_addr = 5'd9; alu_val = 32'h600;
      tick();
      @(negedge clk_in);
      chk("rstb_req_before", mbus.mem_req, 32'd1);
      tick();
      rst_in = 1'b0;
      bubble();
      #1;
      chk("rstb_req_now",  mbus.mem_req, 32'd0);
      chk("rstb_stall",    stall_req,    32'd0);
      chk("rstb_ins",      out_ins_type, {25'd0, OPC_ALOPI});
      tick();
      rst_in = 1'b1;
      @(negedge clk_in);
      chk("rstb_idle_stall", stall_req,    32'd0);
      chk("rstb_idle_req",   mbus.mem_req, 32'd0);
      chk("rstb_idle_ins",   out_ins_type, {25'd0, OPC_ALOPI});
      chk("rstb_idle_rd",    out_rd_addr,  32'd0);

      // randomized transactions against the reference model
      for (int n = 0; n < 40; n++) begin
         sel    = $urandom_range(0, 4);
         r_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                              : 32'h1000 + 32'($urandom_range(0, 31));
         r_sval = $urandom;
         r_mode = $urandom_range(0, 2);
         if (sel <= 1) begin
            r_ins = OPC_LOAD;
            r_f3  = 3'($urandom_range(0, 7));
            r_exp = model_load(r_f3, r_addr);
            do_txn(r_ins, r_f3, 5'($urandom_range(0, 31)), r_addr, r_sval, r_mode, r_exp,
                   (r_mode == 0) ? nbytes_of(r_f3) + 1 : 0);
         end else if (sel <= 3) begin
            r_f3 = 3'($urandom_range(0, 2));
            do_txn(OPC_STORE, r_f3, 5'($urandom_range(0, 31)), r_addr, r_sval, r_mode, 32'd0,
                   (r_mode == 0) ? nbytes_of(r_f3) + 1 : 0);
         end else begin
            r_ins = ($urandom_range(0, 1) == 0) ? OPC_ALOPI : 7'b0110111;
            do_pass(r_ins, 5'($urandom_range(0, 31)), $urandom);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
